pong_anim_graphics: RTL and testbench

Animated, parametrised successor to the static pong pixel generator. Per frame it moves a square ball and a button-driven paddle and bounces the ball off the top wall, bottom wall, left wall and paddle. It counts hits and misses and serves again after a programmable delay. It sits between the VGA sync generator (pixel_x, pixel_y, video_on) and the RGB output pins, and renders one registered 12-bit colour per pixel.

---
 rtl/pong_anim_graphics.sv | 188 ++++++++++++++++++
 tb/tb_pong_anim_graphics.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_anim_graphics.sv
// Animated pong renderer: per-frame ball/paddle motion, wall and paddle bounces,
// hit/miss counting with a timed serve, and one registered 12-bit colour per pixel.
module pong_anim_graphics #(
    parameter int          H_DISP       = 640,
    parameter int          V_DISP       = 480,
    parameter int          WALL_L       = 32,
    parameter int          WALL_R       = 35,
    parameter int          PAD_L        = 600,
    parameter int          PAD_R        = 603,
    parameter int          PAD_H        = 72,
    parameter int          PAD_V        = 4,
    parameter int          BALL_SIZE    = 8,
    parameter int          BALL_V       = 2,
    parameter int          SERVE_FRAMES = 60,
    parameter logic [11:0] WALL_RGB     = 12'h060,
    parameter logic [11:0] PAD_RGB      = 12'h060,
    parameter logic [11:0] BALL_RGB     = 12'hF0F,
    parameter logic [11:0] BG_RGB       = 12'h808
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] graphics_rgb,
    output logic        hit,
    output logic        miss,
    output logic [7:0]  hit_cnt,
    output logic [7:0]  miss_cnt
);

    localparam int SC_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_FRAMES - 1);

    // Geometry widened to 11 bits so sums such as pad_y+PAD_H never wrap.
    localparam logic [10:0] W_L     = 11'(WALL_L);
    localparam logic [10:0] W_R     = 11'(WALL_R);
    localparam logic [10:0] P_L     = 11'(PAD_L);
    localparam logic [10:0] P_R     = 11'(PAD_R);
    localparam logic [10:0] P_H     = 11'(PAD_H);
    localparam logic [10:0] P_V     = 11'(PAD_V);
    localparam logic [10:0] B_S     = 11'(BALL_SIZE);
    localparam logic [10:0] B_V     = 11'(BALL_V);
    localparam logic [10:0] V_D     = 11'(V_DISP);
    localparam logic [10:0] PAD_MAX = 11'(V_DISP - PAD_H);
    localparam logic [9:0]  BALL_X0 = 10'(H_DISP / 2);
    localparam logic [9:0]  BALL_Y0 = 10'(V_DISP / 2);
    localparam logic [9:0]  PAD_Y0  = 10'((V_DISP - PAD_H) / 2);

    typedef enum logic {SERVE, PLAY} state_t;

    state_t          state, state_n;
    logic [SC_W-1:0] serve_cnt, serve_cnt_n;
    logic [9:0]      ball_x, ball_y, ball_x_n, ball_y_n;
    logic            dir_x, dir_y, dir_x_n, dir_y_n;
    logic [9:0]      pad_y, pad_y_n;
    logic            hit_n, miss_n;
    logic [7:0]      hit_cnt_n, miss_cnt_n;
    logic            frame_cond, frame_cond_d, tick;
    logic [11:0]     rgb_n;

    logic [10:0] bx, by, b_r, b_b, pad_top, pad_bot, px, py;

    assign bx      = {1'b0, ball_x};
    assign by      = {1'b0, ball_y};
    assign b_r     = bx + B_S - 11'd1;
    assign b_b     = by + B_S - 11'd1;
    assign pad_top = {1'b0, pad_y};
    assign pad_bot = pad_top + P_H - 11'd1;
    assign px      = {1'b0, pixel_x};
    assign py      = {1'b0, pixel_y};

    // Edge-detect the frame position so a slow pixel clock still yields one tick per frame.
    assign frame_cond = (py == V_D) && (px == 11'd0);
    assign tick       = frame_cond & ~frame_cond_d;

    always_comb begin
        pad_y_n = pad_y;
        if (btn_up && !btn_down)
            pad_y_n = (pad_top >= P_V) ? 10'(pad_top - P_V) : 10'd0;
        else if (btn_down && !btn_up)
            pad_y_n = (pad_top + P_V > PAD_MAX) ? 10'(PAD_MAX) : 10'(pad_top + P_V);
    end

    always_comb begin
        state_n     = state;
        serve_cnt_n = serve_cnt;
        ball_x_n    = ball_x;
        ball_y_n    = ball_y;
        dir_x_n     = dir_x;
        dir_y_n     = dir_y;
        hit_n       = 1'b0;
        miss_n      = 1'b0;
        hit_cnt_n   = hit_cnt;
        miss_cnt_n  = miss_cnt;
        case (state)
            SERVE: begin
                if (serve_cnt == SERVE_LAST) begin
                    serve_cnt_n = '0;
                    dir_x_n     = 1'b1;
                    dir_y_n     = 1'b1;
                    state_n     = PLAY;
                end else begin
                    serve_cnt_n = serve_cnt + SC_W'(1);
                end
            end
            PLAY: begin
                if (bx > P_R) begin
                    miss_n     = 1'b1;
                    miss_cnt_n = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
                    ball_x_n   = BALL_X0;
                    ball_y_n   = BALL_Y0;
                    state_n    = SERVE;
                end else begin
                    // Paddle has priority over the left wall if both ever match.
                    if (dir_x && b_r >= P_L && b_r <= P_R && b_b >= pad_top && by <= pad_bot) begin
                        dir_x_n   = 1'b0;
                        hit_n     = 1'b1;
                        hit_cnt_n = (hit_cnt == 8'hFF) ? hit_cnt : hit_cnt + 8'd1;
                    end else if (bx <= W_R + B_V) begin
                        dir_x_n = 1'b1;
                    end
                    if (by <= B_V)
                        dir_y_n = 1'b1;
                    else if (b_b >= V_D - 11'd1 - B_V)
                        dir_y_n = 1'b0;
                    ball_x_n = dir_x_n ? 10'(bx + B_V) : 10'(bx - B_V);
                    ball_y_n = dir_y_n ? 10'(by + B_V) : 10'(by - B_V);
                end
            end
            default: state_n = SERVE;
        endcase
    end

    always_comb begin
        rgb_n = BG_RGB;
        if (!video_on)
            rgb_n = 12'h000;
        else if (px >= W_L && px <= W_R)
            rgb_n = WALL_RGB;
        else if (px >= P_L && px <= P_R && py >= pad_top && py <= pad_bot)
            rgb_n = PAD_RGB;
        else if (px >= bx && px <= b_r && py >= by && py <= b_b)
            rgb_n = BALL_RGB;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= SERVE;
        else if (tick)
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            serve_cnt    <= '0;
            ball_x       <= BALL_X0;
            ball_y       <= BALL_Y0;
            dir_x        <= 1'b1;
            dir_y        <= 1'b1;
            pad_y        <= PAD_Y0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            hit_cnt      <= 8'd0;
            miss_cnt     <= 8'd0;
            graphics_rgb <= 12'h000;
            frame_cond_d <= 1'b0;
        end else begin
            frame_cond_d <= frame_cond;
            graphics_rgb <= rgb_n;
            hit          <= tick & hit_n;
            miss         <= tick & miss_n;
            if (tick) begin
                serve_cnt <= serve_cnt_n;
                ball_x    <= ball_x_n;
                ball_y    <= ball_y_n;
                dir_x     <= dir_x_n;
                dir_y     <= dir_y_n;
                pad_y     <= pad_y_n;
                hit_cnt   <= hit_cnt_n;
                miss_cnt  <= miss_cnt_n;
            end
        end
    end

endmodule

// File: tb/tb_pong_anim_graphics.sv
// Randomised bench for pong_anim_graphics against a frame-level game model; a second
// instance with the paddle left of centre and a 1-frame serve exercises miss saturation.
module tb_pong_anim_graphics;

    localparam int H_DISP = 640, V_DISP = 480, WALL_L = 32, WALL_R = 35;
    localparam int PAD_L = 600, PAD_R = 603, PAD_H = 72, PAD_V = 4;
    localparam int BALL_SIZE = 8, BALL_V = 2, SERVE_FRAMES = 60;

    logic        clk = 1'b0;
    logic        reset_n, video_on, btn_up, btn_down;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] graphics_rgb, f_rgb;
    logic        hit, miss, f_hit, f_miss;
    logic [7:0]  hit_cnt, miss_cnt, f_hit_cnt, f_miss_cnt;

    always #5 clk = ~clk;

    pong_anim_graphics dut (
        .clk(clk), .reset_n(reset_n), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .btn_up(btn_up), .btn_down(btn_down),
        .graphics_rgb(graphics_rgb), .hit(hit), .miss(miss),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    pong_anim_graphics #(.PAD_L(300), .PAD_R(303), .SERVE_FRAMES(1)) dut_fast (
        .clk(clk), .reset_n(reset_n), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .btn_up(btn_up), .btn_down(btn_down),
        .graphics_rgb(f_rgb), .hit(f_hit), .miss(f_miss),
        .hit_cnt(f_hit_cnt), .miss_cnt(f_miss_cnt)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int fast_ticks = 0;

    // Frame-level game model: position, velocity signs, serve countdown, scores.
    int m_bx, m_by, m_vx, m_vy, m_pad, m_serve, m_hits, m_misses;
    bit m_play;

    task automatic model_reset();
        m_bx = H_DISP / 2; m_by = V_DISP / 2; m_vx = 1; m_vy = 1;
        m_pad = (V_DISP - PAD_H) / 2; m_serve = 0; m_play = 0;
        m_hits = 0; m_misses = 0;
    endtask

    task automatic model_tick(input bit up, input bit down, output bit eh, output bit em);
        int br, bb;
        eh = 0; em = 0;
        br = m_bx + BALL_SIZE - 1;
        bb = m_by + BALL_SIZE - 1;
        if (!m_play) begin
            m_serve++;
            if (m_serve == SERVE_FRAMES) begin
                m_serve = 0; m_vx = 1; m_vy = 1; m_play = 1;
            end
        end else if (m_bx > PAD_R) begin
            em = 1;
            m_misses = (m_misses < 255) ? m_misses + 1 : 255;
            m_bx = H_DISP / 2; m_by = V_DISP / 2; m_play = 0;
        end else begin
            if (m_vx > 0 && br >= PAD_L && br <= PAD_R && bb >= m_pad && m_by <= m_pad + PAD_H - 1) begin
                m_vx = -1; eh = 1;
                m_hits = (m_hits < 255) ? m_hits + 1 : 255;
            end else if (m_bx <= WALL_R + BALL_V) begin
                m_vx = 1;
            end
            if (m_by <= BALL_V) m_vy = 1;
            else if (bb >= V_DISP - 1 - BALL_V) m_vy = -1;
            m_bx = m_bx + m_vx * BALL_V;
            m_by = m_by + m_vy * BALL_V;
        end
        if (up && !down) m_pad = (m_pad - PAD_V < 0) ? 0 : m_pad - PAD_V;
        else if (down && !up) m_pad = (m_pad + PAD_V > V_DISP - PAD_H) ? V_DISP - PAD_H : m_pad + PAD_V;
    endtask

    function automatic logic [11:0] model_rgb(input int x, input int y, input bit von);
        if (!von) return 12'h000;
        if (x >= WALL_L && x <= WALL_R) return 12'h060;
        if (x >= PAD_L && x <= PAD_R && y >= m_pad && y < m_pad + PAD_H) return 12'h060;
        if (x >= m_bx && x < m_bx + BALL_SIZE && y >= m_by && y < m_by + BALL_SIZE) return 12'hF0F;
        return 12'h808;
    endfunction

    // One frame: present the tick position for one clk, then check pulses and scores.
    task automatic do_tick(input bit up, input bit down);
        bit eh, em;
        @(negedge clk);
        n_cmp++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pulse_width: hit=%0b miss=%0b, required 0 0", hit, miss);
        end
        pixel_x = 10'd0; pixel_y = 10'(V_DISP); video_on = 1'b0;
        btn_up = up; btn_down = down;
        model_tick(up, down, eh, em);
        @(negedge clk);
        fast_ticks++;
        n_cmp++;
        if (hit !== eh || miss !== em) begin
            n_fail++;
            $display("[TB] FAIL tick_pulse: hit=%0b miss=%0b, required %0b %0b", hit, miss, eh, em);
        end
        n_cmp++;
        if (hit_cnt !== 8'(m_hits) || miss_cnt !== 8'(m_misses)) begin
            n_fail++;
            $display("[TB] FAIL scores: hit_cnt=%0d miss_cnt=%0d, required %0d %0d",
                     hit_cnt, miss_cnt, m_hits, m_misses);
        end
        pixel_x = 10'd5; pixel_y = 10'd0; btn_up = 1'b0; btn_down = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input bit von);
        logic [11:0] exp;
        if (x < 0) x = 0;
        if (x > H_DISP - 1) x = H_DISP - 1;
        if (y < 0) y = 0;
        if (y > V_DISP - 1) y = V_DISP - 1;
        @(negedge clk);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
        exp = model_rgb(x, y, von);
        @(negedge clk);
        n_cmp++;
        if (graphics_rgb !== exp) begin
            n_fail++;
            $display("[TB] FAIL render(%0d,%0d,von=%0b): got %h, required %h", x, y, von, graphics_rgb, exp);
        end
    endtask

    task automatic check_scene();
        int r;
        probe(m_bx + 3, m_by + 3, 1);
        probe(m_bx - 1, m_by + 3, 1);
        probe(m_bx + BALL_SIZE - 1, m_by + BALL_SIZE - 1, 1);
        probe(m_bx + 3, m_by + BALL_SIZE, 1);
        probe(PAD_L + 1, m_pad, 1);
        probe(PAD_R, m_pad + PAD_H - 1, 1);
        probe(PAD_L, m_pad + PAD_H, 1);
        probe(PAD_R + 1, m_pad + 1, 1);
        r = $urandom_range(0, V_DISP - 1);
        probe(WALL_L, r, 1);
        probe(WALL_R + 1, r, 1);
        probe($urandom_range(0, H_DISP - 1), $urandom_range(0, V_DISP - 1), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (graphics_rgb !== 12'h000 || hit !== 1'b0 || miss !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: rgb=%h hit=%0b miss=%0b, required 000 0 0", graphics_rgb, hit, miss);
        end
        n_cmp++;
        if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_counts: %0d %0d, required 0 0", hit_cnt, miss_cnt);
        end
        reset_n = 1'b1;
        model_reset();
        fast_ticks = 0;
    endtask

    task automatic test_serve();
        repeat (59) do_tick(0, 0);
        check_scene();
        do_tick(0, 0);
        check_scene();
        do_tick(0, 0);
        check_scene();
        @(negedge clk); pixel_x = 10'd322; pixel_y = 10'd242; video_on = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (graphics_rgb !== 12'hF0F) begin
            n_fail++;
            $display("[TB] FAIL first_move_ball: got %h, required F0F", graphics_rgb);
        end
        pixel_x = 10'd321;
        @(negedge clk);
        n_cmp++;
        if (graphics_rgb !== 12'h808) begin
            n_fail++;
            $display("[TB] FAIL first_move_bg: got %h, required 808", graphics_rgb);
        end
        pixel_x = 10'd601; pixel_y = 10'd210;
        @(negedge clk);
        n_cmp++;
        if (graphics_rgb !== 12'h060) begin
            n_fail++;
            $display("[TB] FAIL paddle_start: got %h, required 060", graphics_rgb);
        end
    endtask

    task automatic test_paddle();
        repeat (60) do_tick(1, 0);
        check_scene();
        repeat (150) do_tick(0, 1);
        check_scene();
        repeat (5) do_tick(1, 1);
        check_scene();
    endtask

    task automatic test_render();
        probe(33, 100, 0);
        probe(33, 100, 1);
        probe(100, 100, 1);
        @(negedge clk); pixel_x = 10'd33; pixel_y = 10'd100; video_on = 1'b1;
        @(negedge clk);
        pixel_x = 10'd100; pixel_y = 10'd100; video_on = 1'b0;
        #1;
        n_cmp++;
        if (graphics_rgb !== 12'h060) begin
            n_fail++;
            $display("[TB] FAIL render_latency_hold: got %h, required 060", graphics_rgb);
        end
        @(negedge clk);
        n_cmp++;
        if (graphics_rgb !== 12'h000) begin
            n_fail++;
            $display("[TB] FAIL render_blank: got %h, required 000", graphics_rgb);
        end
    endtask

    task automatic test_hit();
        int start, k;
        bit up, down;
        start = m_hits;
        k = 0;
        while (m_hits == start && k < 1000) begin
            up   = (m_by + 4) < (m_pad + 34);
            down = (m_by + 4) > (m_pad + 38);
            do_tick(up, down);
            k++;
        end
        n_cmp++;
        if (m_hits == start || hit_cnt !== 8'(m_hits)) begin
            n_fail++;
            $display("[TB] FAIL hit_scenario: hit_cnt=%0d after %0d frames, required %0d", hit_cnt, k, start + 1);
        end
        do_tick(0, 0);
        check_scene();
    endtask

    task automatic test_miss();
        int start, k;
        bit up;
        start = m_misses;
        k = 0;
        while (m_misses == start && k < 1500) begin
            up = (m_by + 4) >= (V_DISP / 2);
            do_tick(up, !up);
            k++;
        end
        n_cmp++;
        if (m_misses == start || miss_cnt !== 8'(m_misses)) begin
            n_fail++;
            $display("[TB] FAIL miss_scenario: miss_cnt=%0d after %0d frames, required %0d", miss_cnt, k, start + 1);
        end
        check_scene();
    endtask

    task automatic test_random_play();
        for (int i = 0; i < 1200; i++) begin
            do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i % 40 == 39) check_scene();
        end
    endtask

    task automatic test_mid_reset();
        repeat (20) do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clk); pixel_x = 10'd33; pixel_y = 10'd50; video_on = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (graphics_rgb !== 12'h000 || hit_cnt !== 8'd0 || miss_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: rgb=%h hit_cnt=%0d miss_cnt=%0d, required 000 0 0",
                     graphics_rgb, hit_cnt, miss_cnt);
        end
        pixel_x = 10'd5; pixel_y = 10'd0; video_on = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        fast_ticks = 0;
        probe(324, 244, 1);
        probe(601, 204, 1);
        probe(601, 276, 1);
        n_cmp++;
        if (graphics_rgb !== 12'h808) begin
            n_fail++;
            $display("[TB] FAIL reset_paddle_home: got %h, required 808", graphics_rgb);
        end
        check_scene();
    endtask

    task automatic test_miss_saturation();
        while (fast_ticks < 2) do_tick(0, 0);
        n_cmp++;
        if (f_miss_cnt !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL sat_first_miss: got %0d, required 1", f_miss_cnt);
        end
        while (fast_ticks < 508) do_tick(0, 0);
        n_cmp++;
        if (f_miss_cnt !== 8'd254) begin
            n_fail++;
            $display("[TB] FAIL sat_254: got %0d, required 254", f_miss_cnt);
        end
        while (fast_ticks < 510) do_tick(0, 0);
        n_cmp++;
        if (f_miss_cnt !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL sat_255: got %0d, required 255", f_miss_cnt);
        end
        while (fast_ticks < 600) do_tick(0, 0);
        n_cmp++;
        if (f_miss_cnt !== 8'd255 || f_hit_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL sat_hold: miss_cnt=%0d hit_cnt=%0d, required 255 0", f_miss_cnt, f_hit_cnt);
        end
    endtask

    initial begin
        reset_n = 1'b0; video_on = 1'b0; pixel_x = 10'd5; pixel_y = 10'd0;
        btn_up = 1'b0; btn_down = 1'b0;
        model_reset();
        test_reset();
        test_serve();
        test_paddle();
        test_render();
        test_hit();
        test_miss();
        test_random_play();
        test_mid_reset();
        test_miss_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
